rm_alert_collector: RTL and testbench
=====================================

Name: rm_alert_collector

Overview:
- Consumer end of the runtime-monitor lane datapath. Reads the per-lane rule-hit vectors produced by rm_monitor.
- Turns newly asserted rule bits into discrete alert records: {lane, rules, pc}.
- Buffers records in a small FIFO and hands them out over a valid/ready interface to the CSR/trap logic.
- Keeps a sticky overflow flag and a saturating lost-alert counter so that software can detect merged alerts.

Parameters:
- NUM_LANES, 6, number of monitor lanes.
- NUM_RULES, 5, rule bits per lane.
- FIFO_DEPTH, 4, alert FIFO entries; power of two, ≥2.
- LANE_W, $clog2(NUM_LANES), width of the lane index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- monitor_i  in  [NUM_LANES-1:0][NUM_RULES-1:0]  per-lane rule-hit vector from rm_monitor.
- lane_reset_i  in  [NUM_LANES-1:0]  per-lane reset from rm_event_router.
- lane_pc_i  in  [NUM_LANES-1:0][riscv::VLEN-1:0]  PC currently bound to each lane.
- clear_i  in  1  synchronous clear of overflow_o and drop_cnt_o.
- alert_valid_o  out  1  FIFO head valid.
- alert_ready_i  in  1  consumer accepts the head.
- alert_lane_o  out  LANE_W  lane of the head record.
- alert_rules_o  out  NUM_RULES  rule bits of the head record.
- alert_pc_o  out  riscv::VLEN  PC of the head record.
- pending_o  out  NUM_LANES  per-lane pending flag (captured, not yet in FIFO).
- overflow_o  out  1  sticky: at least one alert was merged.
- drop_cnt_o  out  8  saturating count of merges.

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0.
  - prev, pending, FIFO pointers and count are 0.
  - Round-robin pointer is 0.
- Edge detect, per lane l:
  - rise[l] = monitor_i[l] & ~prev[l].
  - prev[l] <= monitor_i[l] every cycle.
  - If lane_reset_i[l]=1: prev[l] <= 0 and rise[l] is forced to 0 that cycle.
- Pending capture, per lane: registers pend_rules[l] and pend_pc[l]; pending[l] = |pend_rules[l].
  - rise[l]≠0, lane not pending: pend_rules <= rise, pend_pc <= lane_pc_i[l].
  - rise[l]≠0, lane pending and not granted this cycle: pend_rules |= rise and pend_pc is kept. This is a merge: overflow_o <= 1, drop_cnt_o++ (saturate at 255).
  - rise[l]≠0, lane granted this cycle: the granted entry carries the old contents; pend_rules <= rise and pend_pc <= lane_pc_i[l]. This is not a merge.
  - lane_reset_i never discards pending or FIFO contents.
- Arbiter and FIFO push:
  - Each cycle in which the FIFO is not full, grant the first pending lane searching from the RR pointer upward, with wrap-around.
  - On a grant: write {lane, pend_rules, pend_pc} into the FIFO, clear that lane's pending (unless a new rise reloads it), and set pointer <= (g+1) mod NUM_LANES.
  - At most one push per cycle.
  - FIFO full: no grant; pending is held (backpressure); merges continue to count.
- FIFO pop:
  - alert_valid_o = count≠0; alert_* outputs come straight from the head register.
  - Pop on alert_valid_o & alert_ready_i.
  - Push and pop in the same cycle are both allowed when full: the pop frees the slot and the push is granted in that same cycle. The count is unchanged.
- Latency: a rise sampled at edge N sets pending after N. With no contention and the FIFO not full, it is pushed at edge N+1, so alert_valid_o=1 in cycle N+2.
- Merge counting and clear:
  - Merges on several lanes in the same cycle add their number to drop_cnt_o, saturating.
  - clear_i=1: overflow_o <= 0, drop_cnt_o <= 0. A merge in the same cycle wins, giving overflow_o=1 and drop_cnt_o=the merge count.
  - clear_i does not flush the FIFO or pending.
- Reset mid-operation: async reset clears everything immediately, including FIFO contents and alert_valid_o.

Test Plan:
- Single alert:
  - Stimulus: monitor_i[2] 0→5'b00100 with lane_pc_i[2]=0x8000_0040; alert_ready_i=1.
  - Required: 2 cycles later alert_valid_o=1 for exactly 1 cycle, with lane=2, rules=00100, pc=0x8000_0040. Holding monitor_i high produces no further alert.
- Round-robin:
  - Stimulus: lanes 1, 3 and 5 rise in the same cycle; alert_ready_i=1.
  - Required: pops occur in order lane 1, 3, 5 on consecutive cycles. Then lanes 0 and 4 rise together; with the pointer at 0 (reached by wrap-around after the lane-5 grant), lane 0 is popped first, then lane 4.
- Backpressure and merge:
  - Stimulus: alert_ready_i=0; rises on lanes 0–3 fill FIFO_DEPTH=4; then lane 4 rises (01000) and re-rises with 00010 after a fall.
  - Required: pending_o[4]=1; overflow_o=1; drop_cnt_o=1. After ready goes to 1, the 5th record popped has lane=4, rules=01010, and the pc captured at the first rise.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full and a lane pending; ready pulsed for 1 cycle.
  - Required: count stays 4 and the pending lane's entry appears at the tail.
- Lane reset:
  - Stimulus: lane_reset_i[1]=1 in the same cycle monitor_i[1] rises.
  - Required: no alert. On the next cycle with monitor_i[1] still high, an alert is generated, because prev was cleared.
- Clear and saturation:
  - Stimulus: force 300 merges, then assert clear_i.
  - Required: drop_cnt_o=255 before clear_i and 0 after. The FIFO contents are intact.

Source files
------------

// File: rtl/rm_alert_collector.sv
// Turns rising rule bits from the monitor lanes into {lane, rules, pc} alert records behind a valid/ready FIFO.
// Latency: alert valid two edges after the rise. A full FIFO holds records in the per-lane pending slots, and new rises there are merged and counted.

module rm_alert_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         empty,
   output logic         full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   assign rdata = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign full  = (cnt == (AW+1)'(DEPTH));

   // Storage is reset too, so the head reads as zero after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

module rm_alert_collector #(
   parameter int NUM_LANES  = 6,
   parameter int NUM_RULES  = 5,
   parameter int FIFO_DEPTH = 4,
   parameter int VLEN       = 32,
   parameter int LANE_W     = $clog2(NUM_LANES)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NUM_LANES-1:0][NUM_RULES-1:0]  monitor_i,
   input  logic [NUM_LANES-1:0]                 lane_reset_i,
   input  logic [NUM_LANES-1:0][VLEN-1:0]       lane_pc_i,
   input  logic                                 clear_i,
   output logic                                 alert_valid_o,
   input  logic                                 alert_ready_i,
   output logic [LANE_W-1:0]                    alert_lane_o,
   output logic [NUM_RULES-1:0]                 alert_rules_o,
   output logic [VLEN-1:0]                      alert_pc_o,
   output logic [NUM_LANES-1:0]                 pending_o,
   output logic                                 overflow_o,
   output logic [7:0]                           drop_cnt_o
);
   localparam int REC_W  = LANE_W + NUM_RULES + VLEN;
   localparam int MCNT_W = $clog2(NUM_LANES + 1);

   logic [NUM_LANES-1:0][NUM_RULES-1:0] prev, rise, pend_rules;
   logic [NUM_LANES-1:0][VLEN-1:0]      pend_pc;
   logic [NUM_LANES-1:0]                merge;
   logic [LANE_W-1:0]                   rr_ptr, gnt_idx;
   logic                                gnt_found, grant, pop, fifo_full, fifo_empty;
   logic [MCNT_W-1:0]                   merge_cnt;
   logic [8:0]                          drop_sum;
   logic [REC_W-1:0]                    push_rec, head_rec;

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         rise[l]      = lane_reset_i[l] ? '0 : (monitor_i[l] & ~prev[l]);
         pending_o[l] = |pend_rules[l];
      end
   end

   // Round-robin search starting at rr_ptr, wrapping past the last lane.
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_LANES) idx = idx - NUM_LANES;
         if (!gnt_found && pending_o[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = LANE_W'(idx);
         end
      end
   end

   assign pop           = ~fifo_empty & alert_ready_i;
   assign grant         = gnt_found & (~fifo_full | alert_ready_i);
   assign alert_valid_o = ~fifo_empty;
   assign push_rec      = {gnt_idx, pend_rules[gnt_idx], pend_pc[gnt_idx]};
   assign {alert_lane_o, alert_rules_o, alert_pc_o} = head_rec;

   always_comb begin
      merge_cnt = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         merge[l]  = (|rise[l]) & pending_o[l] & ~(grant && (gnt_idx == LANE_W'(l)));
         merge_cnt = merge_cnt + MCNT_W'(merge[l]);
      end
   end

   assign drop_sum = {1'b0, drop_cnt_o} + 9'(merge_cnt);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev       <= '0;
         pend_rules <= '0;
         pend_pc    <= '0;
         rr_ptr     <= '0;
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            prev[l] <= lane_reset_i[l] ? '0 : monitor_i[l];
            // A granted lane hands its old contents to the FIFO and reloads from this cycle's rise.
            if (grant && (gnt_idx == LANE_W'(l))) begin
               pend_rules[l] <= rise[l];
               pend_pc[l]    <= lane_pc_i[l];
            end else if (|rise[l]) begin
               if (pending_o[l]) begin
                  pend_rules[l] <= pend_rules[l] | rise[l];
               end else begin
                  pend_rules[l] <= rise[l];
                  pend_pc[l]    <= lane_pc_i[l];
               end
            end
         end
         if (grant) rr_ptr <= (gnt_idx == LANE_W'(NUM_LANES-1)) ? '0 : gnt_idx + 1'b1;
         if (clear_i) begin
            overflow_o <= |merge;
            drop_cnt_o <= 8'(merge_cnt);
         end else begin
            if (|merge) overflow_o <= 1'b1;
            drop_cnt_o <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
         end
      end
   end

   rm_alert_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (grant),
      .pop   (pop),
      .wdata (push_rec),
      .rdata (head_rec),
      .empty (fifo_empty),
      .full  (fifo_full)
   );
endmodule

// File: tb/tb_rm_alert_collector.sv
// Directed and randomized bench for rm_alert_collector against a queue-based alert model.
module tb_rm_alert_collector;
   localparam int NL = 6;
   localparam int NR = 5;
   localparam int DEPTH = 4;

   logic                  clk, rst_n;
   logic [NL-1:0][NR-1:0] mon;
   logic [NL-1:0]         lrst;
   logic [NL-1:0][31:0]   lpc;
   logic                  clr, rdy;
   logic                  valid;
   logic [2:0]            lane;
   logic [NR-1:0]         rules;
   logic [31:0]           pc;
   logic [NL-1:0]         pending;
   logic                  ovf;
   logic [7:0]            drop;

   rm_alert_collector dut (
      .clk_i(clk), .rst_ni(rst_n), .monitor_i(mon), .lane_reset_i(lrst), .lane_pc_i(lpc),
      .clear_i(clr), .alert_valid_o(valid), .alert_ready_i(rdy), .alert_lane_o(lane),
      .alert_rules_o(rules), .alert_pc_o(pc), .pending_o(pending), .overflow_o(ovf),
      .drop_cnt_o(drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {int lane; logic [NR-1:0] rules; logic [31:0] pc;} rec_t;
   rec_t          q[$];
   logic [NR-1:0] m_prev[NL];
   logic [NR-1:0] m_rules[NL];
   logic [31:0]   m_pc[NL];
   int            m_rr, m_drop;
   bit            m_ovf;
   int            tests, fails, seen4;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int l = 0; l < NL; l++) begin
         m_prev[l] = '0; m_rules[l] = '0; m_pc[l] = '0;
      end
      m_rr = 0; m_drop = 0; m_ovf = 0;
   endtask

   // One clock of the alert rules, using the inputs the DUT samples on the coming edge.
   task automatic model_update();
      logic [NR-1:0] r[NL];
      int g, nm;
      bit do_pop, can_push;
      g = -1; nm = 0;
      do_pop   = (q.size() != 0) && rdy;
      can_push = (q.size() < DEPTH) || rdy;
      for (int l = 0; l < NL; l++) r[l] = lrst[l] ? '0 : (mon[l] & ~m_prev[l]);
      if (can_push)
         for (int i = 0; i < NL; i++)
            if (g < 0 && m_rules[(m_rr + i) % NL] != 0) g = (m_rr + i) % NL;
      if (do_pop) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back('{g, m_rules[g], m_pc[g]});
         m_rules[g] = '0;
         m_rr = (g + 1) % NL;
      end
      for (int l = 0; l < NL; l++) begin
         if (r[l] != 0) begin
            if (m_rules[l] != 0) begin
               m_rules[l] |= r[l];
               nm++;
            end else begin
               m_rules[l] = r[l];
               m_pc[l] = lpc[l];
            end
         end
         m_prev[l] = lrst[l] ? '0 : mon[l];
      end
      if (clr) begin
         m_ovf = (nm > 0);
         m_drop = nm;
      end else begin
         if (nm > 0) m_ovf = 1;
         m_drop = (m_drop + nm > 255) ? 255 : m_drop + nm;
      end
   endtask

   task automatic compare();
      logic [NL-1:0] pv;
      for (int l = 0; l < NL; l++) pv[l] = (m_rules[l] != 0);
      chk("valid", 64'(valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("lane", 64'(lane), 64'(q[0].lane));
         chk("rules", 64'(rules), 64'(q[0].rules));
         chk("pc", 64'(pc), 64'(q[0].pc));
      end
      chk("pending", 64'(pending), 64'(pv));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      chk("drop_cnt", 64'(drop), 64'(m_drop));
   endtask

   task automatic step();
      compare();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      tests = 0; fails = 0; seen4 = 0;
      rst_n = 1'b0; mon = '0; lrst = '0; lpc = '0; clr = 1'b0; rdy = 1'b1;
      model_reset();
      #2;
      chk("reset_valid", 64'(valid), 64'd0);
      chk("reset_pending", 64'(pending), 64'd0);
      chk("reset_overflow", 64'(ovf), 64'd0);
      chk("reset_drop", 64'(drop), 64'd0);
      chk("reset_head", {lane, rules, pc}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single alert on lane 2
      lpc[2] = 32'h8000_0040; mon[2] = 5'b00100;
      steps(2);
      chk("single_valid", 64'(valid), 64'd1);
      chk("single_lane", 64'(lane), 64'd2);
      chk("single_rules", 64'(rules), 64'b00100);
      chk("single_pc", 64'(pc), 64'h8000_0040);
      step();
      chk("single_once", 64'(valid), 64'd0);
      steps(4);

      // Round-robin: lanes 1,3,5 then 0,4
      mon = '0; steps(2);
      for (int l = 1; l < NL; l += 2) begin mon[l] = 5'(l); lpc[l] = 32'h100 + 32'(l); end
      step();
      chk("rr_pending", 64'(pending), 64'b101010);
      steps(6);
      mon[0] = 5'b00011; mon[4] = 5'b10001; lpc[0] = 32'h200; lpc[4] = 32'h204;
      steps(6);

      // Backpressure, merge on lane 4, then full push+pop
      mon = '0; steps(2);
      rdy = 1'b0;
      for (int l = 0; l < 4; l++) begin mon[l] = 5'(l + 1); lpc[l] = 32'h1000 + 32'(l); end
      steps(6);
      mon[4] = 5'b01000; lpc[4] = 32'hAAAA_0004; step();
      mon[4] = 5'b00000; lpc[4] = 32'hBBBB_0004; step();
      mon[4] = 5'b00010; step();
      chk("bp_pending4", 64'(pending[4]), 64'd1);
      chk("bp_overflow", 64'(ovf), 64'd1);
      chk("bp_drop", 64'(drop), 64'd1);
      rdy = 1'b1; step();
      rdy = 1'b0; steps(3);
      rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (valid && lane == 3'd4) begin
            seen4++;
            chk("bp_rules4", 64'(rules), 64'b01010);
            chk("bp_pc4", 64'(pc), 64'hAAAA_0004);
         end
         step();
      end
      chk("bp_seen4", 64'(seen4), 64'd1);

      // Lane reset coinciding with a rise
      mon = '0; steps(2);
      lrst[1] = 1'b1; mon[1] = 5'b10000; step();
      chk("lrst_no_alert", 64'(pending[1]), 64'd0);
      lrst[1] = 1'b0; step();
      chk("lrst_after", 64'(pending[1]), 64'd1);
      steps(4);

      // Saturation of the drop counter, then clear
      mon = '0; steps(2);
      rdy = 1'b0;
      for (int k = 0; k < 110; k++) begin
         for (int l = 0; l < NL; l++) mon[l] = (k % 2 == 0) ? 5'b00001 : 5'b00000;
         lpc = {NL{32'h3000 + 32'(k)}};
         step();
      end
      step();
      chk("sat_drop", 64'(drop), 64'd255);
      clr = 1'b1; step();
      clr = 1'b0;
      chk("clr_drop", 64'(drop), 64'd0);
      chk("clr_overflow", 64'(ovf), 64'd0);
      chk("clr_fifo_kept", 64'(valid), 64'd1);
      rdy = 1'b1; steps(12);

      // Randomized traffic with one asynchronous reset in the middle
      for (int c = 0; c < 600; c++) begin
         rdy = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 40) == 0);
         for (int l = 0; l < NL; l++) begin
            if ($urandom_range(0, 2) == 0) mon[l] = 5'($urandom);
            lrst[l] = ($urandom_range(0, 15) == 0);
            lpc[l] = $urandom;
         end
         if (c == 300) begin
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_valid", 64'(valid), 64'd0);
            chk("midrst_pending", 64'(pending), 64'd0);
            chk("midrst_cnt", {ovf, drop}, 64'd0);
            model_reset();
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
